dog_activity_ctrl: RTL and testbench

DOG_ACTIVITY_CTRL -- requirements
Module: dog_activity_ctrl

---
 rtl/dog_pkg.sv | 35 +++
 rtl/dog_activity_ctrl_button_debounce.sv | 77 +++++++
 rtl/dog_activity_ctrl.sv | 129 ++++++++++++
 tb/tb_dog_activity_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dog_pkg.sv
// Shared activity/speed encodings and the activity sequencing helpers for dog_activity_ctrl.
package dog_pkg;

  typedef enum logic [2:0] {
    STOP = 3'b000,
    WALK = 3'b001,
    RUN  = 3'b010,
    SIT  = 3'b011,
    BARK = 3'b100
  } act_e;

  localparam logic [1:0] SPD_0 = 2'b00;
  localparam logic [1:0] SPD_1 = 2'b01;
  localparam logic [1:0] SPD_2 = 2'b10;
  localparam logic [1:0] SPD_3 = 2'b11;

  function automatic act_e next_act(input act_e a);
    case (a)
      STOP:    next_act = WALK;
      WALK:    next_act = RUN;
      RUN:     next_act = SIT;
      SIT:     next_act = BARK;
      default: next_act = STOP;
    endcase
  endfunction

  function automatic logic [1:0] entry_spd(input act_e a);
    case (a)
      WALK:    entry_spd = SPD_1;
      RUN:     entry_spd = SPD_2;
      default: entry_spd = SPD_0;
    endcase
  endfunction

endpackage

// File: rtl/dog_activity_ctrl_button_debounce.sv
// Button conditioning: 2-flop synchronizer, optional debounce (DOG_DEBOUNCE_EN), armed rising-edge pulse.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press
);

  logic [1:0] sync_q, sync_d;
  logic [1:0] vld_q, vld_d;
  logic       prev_q, prev_d;
  logic       armed_q, armed_d;
  logic       level;

`ifdef DOG_DEBOUNCE_EN
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  localparam int unsigned deb_cycles_unused = DEB_CYCLES;

  assign level = sync_q[1];
`endif

  // vld marks when sync_q[1] holds a genuine post-reset sample; the pulse is only
  // armed once the button has really been seen low, so a held button stays silent.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    vld_d   = {vld_q[0], 1'b1};
    prev_d  = level;
    armed_d = armed_q | (vld_q[1] & ~sync_q[1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign press = level & ~prev_q & armed_q;

endmodule

// File: rtl/dog_activity_ctrl.sv
// Dog activity controller: power toggle, activity/speed sequencing, timed BARK and display scan.
// Build option: DOG_DEBOUNCE_EN enables the button debounce filter.
module dog_activity_ctrl
  import dog_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned SCAN_DIV    = 25000,
  parameter int unsigned BARK_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_onoff,
  input  logic btn_next,
  input  logic btn_spd,
  output logic onoff,
  output logic A_act,
  output logic B_act,
  output logic C_act,
  output logic A_spd,
  output logic B_spd,
  output logic scan
);

  localparam int unsigned BW = (BARK_CYCLES > 1) ? $clog2(BARK_CYCLES) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic onoff_p, next_p, spd_p;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_onoff (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_onoff),
    .press   (onoff_p)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_next (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_next),
    .press   (next_p)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_spd (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_spd),
    .press   (spd_p)
  );

  act_e          act_q, act_d;
  logic [1:0]    spd_q, spd_d;
  logic          onoff_q, onoff_d;
  logic [BW-1:0] bark_cnt_q, bark_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          scan_q, scan_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q      <= STOP;
      spd_q      <= SPD_0;
      onoff_q    <= 1'b0;
      bark_cnt_q <= '0;
      scan_cnt_q <= '0;
      scan_q     <= 1'b0;
    end else begin
      act_q      <= act_d;
      spd_q      <= spd_d;
      onoff_q    <= onoff_d;
      bark_cnt_q <= bark_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_q     <= scan_d;
    end
  end

  // Priority onoff > next > speed falls out of the if/else chain; the BARK timer
  // only counts while staying in BARK, so every other path leaves it cleared.
  always_comb begin
    act_d      = act_q;
    spd_d      = spd_q;
    onoff_d    = onoff_q;
    bark_cnt_d = '0;
    if (onoff_p) begin
      onoff_d = ~onoff_q;
      act_d   = STOP;
      spd_d   = SPD_0;
    end else if (!onoff_q) begin
      act_d = STOP;
      spd_d = SPD_0;
    end else begin
      case (act_q)
        STOP, WALK, RUN, SIT: begin
          if (next_p) begin
            act_d = next_act(act_q);
            spd_d = entry_spd(next_act(act_q));
          end else if (spd_p && (act_q == WALK || act_q == RUN)) begin
            spd_d = (spd_q == SPD_3) ? SPD_1 : spd_q + 2'd1;
          end
        end
        BARK: begin
          if (next_p || bark_cnt_q == BW'(BARK_CYCLES - 1)) begin
            act_d = STOP;
            spd_d = SPD_0;
          end else begin
            bark_cnt_d = bark_cnt_q + BW'(1);
          end
        end
        default: begin
          act_d = STOP;
          spd_d = SPD_0;
        end
      endcase
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_d     = scan_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_d     = ~scan_q;
    end
  end

  assign onoff                 = onoff_q;
  assign {A_act, B_act, C_act} = act_q;
  assign {A_spd, B_spd}        = spd_q;
  assign scan                  = scan_q;

endmodule

// File: tb/tb_dog_activity_ctrl.sv
// Directed self-checking bench for dog_activity_ctrl (DEB_CYCLES=4, SCAN_DIV=2, BARK_CYCLES=8).
module tb_dog_activity_ctrl;

`ifdef DOG_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_onoff, btn_next, btn_spd;
  logic onoff, A_act, B_act, C_act, A_spd, B_spd, scan;
  logic [2:0] act;
  logic [1:0] spd;

  int checks = 0;
  int errors = 0;

  assign act = {A_act, B_act, C_act};
  assign spd = {A_spd, B_spd};

  always #5 clk = ~clk;

  dog_activity_ctrl #(
    .DEB_CYCLES  (4),
    .SCAN_DIV    (2),
    .BARK_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_onoff (btn_onoff),
    .btn_next  (btn_next),
    .btn_spd   (btn_spd),
    .onoff     (onoff),
    .A_act     (A_act),
    .B_act     (B_act),
    .C_act     (C_act),
    .A_spd     (A_spd),
    .B_spd     (B_spd),
    .scan      (scan)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic o, input logic [2:0] a, input logic [1:0] s);
    chk({tag, ".onoff"}, {7'd0, onoff}, {7'd0, o});
    chk({tag, ".act"}, {5'd0, act}, {5'd0, a});
    chk({tag, ".spd"}, {6'd0, spd}, {6'd0, s});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which);
    case (which)
      0:       btn_onoff = 1'b1;
      1:       btn_next  = 1'b1;
      default: btn_spd   = 1'b1;
    endcase
    tick(HOLD);
    btn_onoff = 1'b0;
    btn_next  = 1'b0;
    btn_spd   = 1'b0;
    tick(HOLD);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    btn_onoff = 1'b0;
    btn_next  = 1'b0;
    btn_spd   = 1'b0;
    tick(3);
    chk_state("reset", 1'b0, 3'b000, 2'b00);
    chk("reset.scan", {7'd0, scan}, 8'd0);

    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk("scan_wave", {7'd0, scan}, 8'((k / 2) % 2));
    end
    chk_state("idle", 1'b0, 3'b000, 2'b00);

    press(1);
    chk_state("off_next", 1'b0, 3'b000, 2'b00);
    press(2);
    chk_state("off_spd", 1'b0, 3'b000, 2'b00);

    press(0);
    chk_state("power_on", 1'b1, 3'b000, 2'b00);
    press(1);
    chk_state("walk", 1'b1, 3'b001, 2'b01);
    press(2);
    chk_state("walk_spd1", 1'b1, 3'b001, 2'b10);
    press(2);
    chk_state("walk_spd2", 1'b1, 3'b001, 2'b11);
    press(2);
    chk_state("walk_spd_wrap", 1'b1, 3'b001, 2'b01);
    press(1);
    chk_state("run", 1'b1, 3'b010, 2'b10);
    press(1);
    chk_state("sit", 1'b1, 3'b011, 2'b00);
    press(2);
    chk_state("sit_spd", 1'b1, 3'b011, 2'b00);

    btn_next = 1'b1;
    tick(LAT);
    chk_state("bark_entry", 1'b1, 3'b100, 2'b00);
    btn_next = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chk("bark_hold", {5'd0, act}, 8'd4);
    end
    tick(1);
    chk_state("bark_expire", 1'b1, 3'b000, 2'b00);
    tick(HOLD);

`ifndef DOG_DEBOUNCE_EN
    press(1);
    press(1);
    press(1);
    chk_state("sit_again", 1'b1, 3'b011, 2'b00);
    btn_next = 1'b1;
    tick(LAT);
    chk("bark2_entry", {5'd0, act}, 8'd4);
    btn_next = 1'b0;
    tick(1);
    btn_next = 1'b1;
    tick(1);
    chk("bark2_c2", {5'd0, act}, 8'd4);
    tick(1);
    chk("bark2_c3", {5'd0, act}, 8'd4);
    tick(1);
    chk_state("bark_abort", 1'b1, 3'b000, 2'b00);
    btn_next = 1'b0;
    tick(HOLD);
    chk("abort_stays_stop", {5'd0, act}, 8'd0);
`endif

    press(1);
    press(1);
    chk_state("run_again", 1'b1, 3'b010, 2'b10);
    btn_onoff = 1'b1;
    btn_next  = 1'b1;
    tick(HOLD);
    btn_onoff = 1'b0;
    btn_next  = 1'b0;
    tick(HOLD);
    chk_state("same_cycle", 1'b0, 3'b000, 2'b00);

    press(0);
`ifdef DOG_DEBOUNCE_EN
    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    tick(HOLD);
    chk_state("glitch3", 1'b1, 3'b000, 2'b00);
    btn_next = 1'b1;
    tick(4);
    btn_next = 1'b0;
    tick(HOLD);
    chk_state("held4", 1'b1, 3'b001, 2'b01);
    tick(HOLD);
    chk("held4_once", {5'd0, act}, 8'd1);
`else
    press(1);
    chk_state("walk_again", 1'b1, 3'b001, 2'b01);
`endif

    press(1);
    press(1);
    btn_next = 1'b1;
    tick(LAT);
    chk_state("bark3_entry", 1'b1, 3'b100, 2'b00);
    btn_next = 1'b0;
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    chk_state("async_reset", 1'b0, 3'b000, 2'b00);
    chk("async_reset.scan", {7'd0, scan}, 8'd0);

    btn_onoff = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2 * HOLD);
    chk_state("held_through_reset", 1'b0, 3'b000, 2'b00);
    btn_onoff = 1'b0;
    tick(HOLD);
    press(0);
    chk_state("rearmed", 1'b1, 3'b000, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
